golden_nonce_collector: RTL and testbench
=========================================

GOLDEN_NONCE_COLLECTOR -- requirements
Module: golden_nonce_collector

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO entries; SHALL be a power of 2 in the range 2..16.
REQ-002 Parameter CNT_W, default 16, meaning width of the saturating find counter.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion SHALL clear state immediately; deassertion is synchronised externally.
REQ-005 golden_nonce  input  32  golden-nonce register output of the double-hash miner; 0 means no find.
REQ-006 nonce2  input  32  miner progress nonce, sampled alongside each find.
REQ-007 clear  input  1  synchronous flush, pulsed by the host on new work.
REQ-008 out_ready  input  1  consumer accepts the head entry.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_nonce  output  32  head entry golden nonce.
REQ-011 out_pos  output  32  head entry nonce2 snapshot.
REQ-012 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky flag: at least one find was dropped.
REQ-014 find_count  output  CNT_W  total finds detected since reset or clear, saturating.

Function
REQ-015 Block SHALL hold register prev_nonce, updated to golden_nonce on every clock edge.
REQ-016 Find event SHALL be asserted on an edge where golden_nonce != prev_nonce and golden_nonce != 0.
REQ-017 On a find event, the block SHALL write {golden_nonce, nonce2} as sampled at that edge to the FIFO tail at that same edge.
REQ-018 Entry latency: out_valid SHALL rise in the cycle after the find edge when the FIFO was empty (1 cycle); no combinational path SHALL exist from golden_nonce to out_valid.
REQ-019 Pop SHALL occur on an edge where out_valid and out_ready are both 1; out_nonce and out_pos SHALL present the next entry in the following cycle.
REQ-020 out_nonce and out_pos SHALL be driven from registers or FIFO storage only, never combinationally from inputs.
REQ-021 Entries SHALL be delivered in find order (strict FIFO).
REQ-022 Full (level == DEPTH) with find and no pop: the find SHALL be dropped, overflow set to 1, and FIFO contents unchanged.
REQ-023 Full with find and pop at the same edge: both SHALL occur; level stays DEPTH; overflow is not set.
REQ-024 Empty with find and out_ready=1: no pop SHALL occur at that edge; the entry SHALL become valid next cycle.
REQ-025 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH; level SHALL be derived without ambiguity between full and empty.
REQ-026 find_count SHALL increment on every find event, including dropped ones, and saturate at 2^CNT_W-1 without wrapping.
REQ-027 clear=1 SHALL, at that edge, empty the FIFO and zero level, overflow, and find_count; it SHALL load prev_nonce with the current golden_nonce; clear SHALL win over a simultaneous find or pop.
REQ-028 A golden_nonce transition to 0 (miner reset) SHALL update prev_nonce and SHALL NOT generate a find; a subsequent non-zero value equal to a pre-reset find SHALL count as a new find.

Reset
REQ-029 While reset=0: out_valid=0, level=0, overflow=0, find_count=0, out_nonce=0, out_pos=0, prev_nonce=0, pointers=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first edge after release SHALL behave as from the empty state.

Verification
REQ-031 Single find: with reset released and golden_nonce changing 0 -> 0x1234ABCD while nonce2=0x00000500 and out_ready=0, the bench SHALL see the next cycle out_valid=1, out_nonce=0x1234ABCD, out_pos=0x500, level=1, find_count=1.
REQ-032 Ordering/wrap: with out_ready=0, five finds A1..A5 and DEPTH=4, the bench SHALL see level=4, overflow=1, find_count=5; draining with out_ready=1 SHALL yield A1..A4, then out_valid=0.
REQ-033 Full plus simultaneous find and pop: with the FIFO full and out_ready=1 on the same edge as find B, the bench SHALL see level=4, overflow=0, and B delivered last.
REQ-034 Zero filter: golden_nonce sequence 0x55 -> 0 -> 0x55 SHALL give find_count=2 and no entry for the 0.
REQ-035 Clear priority: clear=1 on the same edge as a find with 2 entries queued SHALL give level=0, out_valid=0, find_count=0 next cycle, and no find from the unchanged golden_nonce afterwards.
REQ-036 Async reset: reset=0 pulsed mid-cycle with 3 entries queued SHALL drop out_valid and level to 0 before the next clock edge.

Source files
------------

// File: rtl/golden_nonce_collector.sv
// golden_nonce_collector: detects new non-zero golden nonces and queues {nonce, nonce2} in a FIFO with sticky overflow and saturating find count.
module golden_nonce_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              golden_nonce,
    input  logic [31:0]              nonce2,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_nonce,
    output logic [31:0]              out_pos,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         find_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   prev_nonce;
    logic          find, full, pop, push;
    always_comb begin
        find      = golden_nonce != prev_nonce && golden_nonce != 32'd0;
        full      = level == FULL_LVL;
        out_valid = level != '0;
        pop       = out_valid && out_ready;
        push      = find && (!full || pop);
        {out_nonce, out_pos} = out_valid ? mem[rd_ptr] : 64'd0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_nonce <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            find_count <= '0;
        end else begin
            prev_nonce <= golden_nonce;
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
                overflow   <= 1'b0;
                find_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                level <= level + (AW+1)'(push) - (AW+1)'(pop);
                if (find && full && !pop) overflow <= 1'b1;
                if (find && find_count != '1) find_count <= find_count + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= {golden_nonce, nonce2};
    end
endmodule

// File: tb/tb_golden_nonce_collector.sv
// tb_golden_nonce_collector: directed stimulus with a queue scoreboard checked by a pop monitor.
module tb_golden_nonce_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] golden_nonce = '0;
    logic [31:0] nonce2 = '0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_nonce, out_pos;
    logic [2:0]  level;
    logic        overflow;
    logic [15:0] find_count;
    int checks = 0;
    int errors = 0;
    logic [63:0] sb [$];

    golden_nonce_collector #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .golden_nonce(golden_nonce), .nonce2(nonce2),
        .clear(clear), .out_ready(out_ready), .out_valid(out_valid),
        .out_nonce(out_nonce), .out_pos(out_pos), .level(level),
        .overflow(overflow), .find_count(find_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] gn, input logic [31:0] n2);
        golden_nonce = gn;
        nonce2 = n2;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(golden_nonce, nonce2);
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop got %h_%h want none", out_nonce, out_pos);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("pop_nonce", out_nonce, e[63:32]);
                chk("pop_pos", out_pos, e[31:0]);
            end
        end
    end

    initial begin
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_cnt", 32'(find_count), 0);
        chk("rst_nonce", out_nonce, 0);
        chk("rst_pos", out_pos, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        step(0, 0);
        // single find
        sb.push_back({32'h1234ABCD, 32'h500});
        step(32'h1234ABCD, 32'h500);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_nonce", out_nonce, 32'h1234ABCD);
        chk("t1_pos", out_pos, 32'h500);
        chk("t1_level", 32'(level), 1);
        chk("t1_cnt", 32'(find_count), 1);
        out_ready = 1'b1;
        step(golden_nonce, 32'h501);
        chk("t1_empty", 32'(out_valid), 0);
        out_ready = 1'b0;
        // ordering and overflow
        do_clear();
        chk("clr_level", 32'(level), 0);
        chk("clr_cnt", 32'(find_count), 0);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back({32'hA0 + 32'(i), 32'h1000 + 32'(i)});
            step(32'hA0 + 32'(i), 32'h1000 + 32'(i));
        end
        chk("t2_level", 32'(level), 4);
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_cnt", 32'(find_count), 5);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(golden_nonce, 0);
        chk("t2_drained", 32'(out_valid), 0);
        chk("t2_sb", 32'(sb.size()), 0);
        out_ready = 1'b0;
        // full with simultaneous find and pop
        do_clear();
        chk("clr_ovf", 32'(overflow), 0);
        for (int i = 1; i <= 4; i++) begin
            sb.push_back({32'hC0 + 32'(i), 32'h2000 + 32'(i)});
            step(32'hC0 + 32'(i), 32'h2000 + 32'(i));
        end
        chk("t3_full", 32'(level), 4);
        out_ready = 1'b1;
        sb.push_back({32'hB0B0B0B0, 32'h3000});
        step(32'hB0B0B0B0, 32'h3000);
        chk("t3_level", 32'(level), 4);
        chk("t3_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) step(golden_nonce, 0);
        chk("t3_drained", 32'(out_valid), 0);
        chk("t3_sb", 32'(sb.size()), 0);
        out_ready = 1'b0;
        // zero filter
        do_clear();
        sb.push_back({32'h55, 32'h10});
        step(32'h55, 32'h10);
        step(32'h0, 32'h11);
        sb.push_back({32'h55, 32'h12});
        step(32'h55, 32'h12);
        chk("t4_cnt", 32'(find_count), 2);
        chk("t4_level", 32'(level), 2);
        out_ready = 1'b1;
        step(golden_nonce, 0);
        step(golden_nonce, 0);
        chk("t4_drained", 32'(out_valid), 0);
        out_ready = 1'b0;
        // clear beats a simultaneous find
        step(32'hD1, 1);
        step(32'hD2, 2);
        chk("t5_pre", 32'(level), 2);
        golden_nonce = 32'hD3;
        do_clear();
        chk("t5_level", 32'(level), 0);
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_cnt", 32'(find_count), 0);
        step(golden_nonce, 3);
        chk("t5_nofind", 32'(find_count), 0);
        chk("t5_level2", 32'(level), 0);
        // async reset mid-cycle
        step(32'hE1, 1);
        step(32'hE2, 2);
        step(32'hE3, 3);
        chk("t6_pre", 32'(level), 3);
        #1;
        reset = 1'b0;
        golden_nonce = 0;
        #1;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_level", 32'(level), 0);
        chk("t6_cnt", 32'(find_count), 0);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_post", 32'(level), 0);
        sb.push_back({32'hF00D, 32'h77});
        step(32'hF00D, 32'h77);
        chk("t6_find", 32'(level), 1);
        out_ready = 1'b1;
        step(golden_nonce, 0);
        chk("t6_drained", 32'(out_valid), 0);
        chk("end_sb", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
